// File: rtl/pipe_stage_reg.sv
// Parametrised inter-phase pipeline register with a valid/ready handshake, 2-entry skid buffer, flush and bubble control zeroing.
// Optional macro PIPE_STAGE_PERF_EN adds saturating stall_cnt / bubble_cnt performance counters.
module pipe_stage_reg #(
    parameter int                DATA_W   = 96,
    parameter int                CTRL_W   = 16,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt,
`endif
    output logic [1:0]        occupancy
);

    // State encoding doubles as the entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [DATA_W-1:0]   main_data_reg, main_data_next;
    logic [CTRL_W-1:0]   main_ctrl_reg, main_ctrl_next;
    logic [DATA_W-1:0]   skid_data_reg, skid_data_next;
    logic [CTRL_W-1:0]   skid_ctrl_reg, skid_ctrl_next;
    logic                in_ready_reg, in_ready_next;
    logic                push;

    assign push = in_valid & in_ready_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= EMPTY;
            main_data_reg <= '0;
            main_ctrl_reg <= CTRL_RST;
            skid_data_reg <= '0;
            skid_ctrl_reg <= CTRL_RST;
            in_ready_reg  <= 1'b1;
        end else begin
            state_reg     <= state_next;
            main_data_reg <= main_data_next;
            main_ctrl_reg <= main_ctrl_next;
            skid_data_reg <= skid_data_next;
            skid_ctrl_reg <= skid_ctrl_next;
            in_ready_reg  <= in_ready_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        main_ctrl_next = main_ctrl_reg;
        skid_data_next = skid_data_reg;
        skid_ctrl_next = skid_ctrl_reg;

        if (flush) begin
            // Held entries and any same-cycle accept are dropped; data bits may linger.
            state_next     = EMPTY;
            main_ctrl_next = CTRL_RST;
            skid_ctrl_next = CTRL_RST;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (push) begin
                        main_data_next = in_data;
                        main_ctrl_next = in_ctrl;
                        state_next     = ONE;
                    end
                end
                ONE: begin
                    if (push && out_ready) begin
                        main_data_next = in_data;
                        main_ctrl_next = in_ctrl;
                    end else if (push) begin
                        skid_data_next = in_data;
                        skid_ctrl_next = in_ctrl;
                        state_next     = TWO;
                    end else if (out_ready) begin
                        main_ctrl_next = CTRL_RST;
                        state_next     = EMPTY;
                    end
                end
                TWO: begin
                    if (out_ready) begin
                        main_data_next = skid_data_reg;
                        main_ctrl_next = skid_ctrl_reg;
                        skid_ctrl_next = CTRL_RST;
                        state_next     = ONE;
                    end
                end
                default: begin
                    state_next     = EMPTY;
                    main_ctrl_next = CTRL_RST;
                    skid_ctrl_next = CTRL_RST;
                end
            endcase
        end

        in_ready_next = (state_next != TWO);
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = (state_reg != EMPTY);
    assign out_data  = main_data_reg;
    // Gate control to CTRL_RST whenever empty so a bubble can never carry a write enable.
    assign out_ctrl  = out_valid ? main_ctrl_reg : CTRL_RST;
    assign occupancy = state_reg;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_reg, bubble_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else if (flush) begin
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (in_valid && !in_ready_reg && (stall_cnt_reg != 32'hFFFF_FFFF))
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (!out_valid && out_ready && (bubble_cnt_reg != 32'hFFFF_FFFF))
                bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt  = stall_cnt_reg;
    assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed steps plus random traffic checked against a FIFO-queue reference model.
module tb_pipe_stage_reg;

    localparam int          DATA_W   = 96;
    localparam int          CTRL_W   = 16;
    localparam logic [15:0] CTRL_RST = 16'hA5A5;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]       stall_cnt, bubble_cnt;
    int unsigned       exp_stall = 0, exp_bubble = 0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_RST(CTRL_RST)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
`ifdef PIPE_STAGE_PERF_EN
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
        .occupancy(occupancy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the queue model of the stage contents.
    task automatic compare(input string step);
        logic exp_v;
        exp_v = (q.size() != 0);
        check({step, ":out_valid"}, 128'(out_valid), 128'(exp_v));
        check({step, ":in_ready"},  128'(in_ready),  128'(q.size() < 2));
        check({step, ":occupancy"}, 128'(occupancy), 128'(q.size()));
        check({step, ":out_ctrl"},  128'(out_ctrl),  128'(exp_v ? q[0].c : CTRL_RST));
        if (exp_v)
            check({step, ":out_data"}, 128'(out_data), 128'(q[0].d));
`ifdef PIPE_STAGE_PERF_EN
        check({step, ":stall_cnt"},  128'(stall_cnt),  128'(exp_stall));
        check({step, ":bubble_cnt"}, 128'(bubble_cnt), 128'(exp_bubble));
`endif
        $display("%s: v=%0b rdy=%0b occ=%0d data=%0h ctrl=%0h", step, out_valid, in_ready, occupancy, out_data, out_ctrl);
    endtask

    // One clock: check outputs, drive inputs, advance the model, then move to the next sample point.
    task automatic cycle(input string step, input logic v, input logic [DATA_W-1:0] d,
                         input logic [CTRL_W-1:0] c, input logic ordy, input logic fl);
        logic push, pop;
        compare(step);
        in_valid = v; in_data = d; in_ctrl = c; out_ready = ordy; flush = fl;
        push = v && (q.size() < 2);
        pop  = (q.size() != 0) && ordy;
`ifdef PIPE_STAGE_PERF_EN
        if (fl) begin
            exp_stall = 0; exp_bubble = 0;
        end else begin
            if (v && q.size() >= 2 && exp_stall != 32'hFFFF_FFFF) exp_stall++;
            if (q.size() == 0 && ordy && exp_bubble != 32'hFFFF_FFFF) exp_bubble++;
        end
`endif
        if (pop) void'(q.pop_front());
        if (fl) q.delete();
        else if (push) q.push_back('{d: d, c: c});
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("reset:out_data", 128'(out_data), 128'(0));
        compare("reset");
        rst = 1'b1;

        // Streaming: 8 beats back to back
        for (int i = 1; i <= 8; i++)
            cycle("stream", 1'b1, DATA_W'(i), 16'h0001, 1'b1, 1'b0);
        cycle("stream_drain", 1'b0, '0, '0, 1'b1, 1'b0);
        cycle("stream_idle", 1'b0, '0, '0, 1'b1, 1'b0);

        // Skid fill then release in order
        cycle("skid_a", 1'b1, 96'hA, 16'h0002, 1'b0, 1'b0);
        cycle("skid_b", 1'b1, 96'hB, 16'h0003, 1'b0, 1'b0);
        cycle("skid_c_blocked", 1'b1, 96'hC, 16'h0004, 1'b0, 1'b0);
        cycle("skid_c_blocked2", 1'b1, 96'hC, 16'h0004, 1'b0, 1'b0);
        cycle("skid_release", 1'b1, 96'hC, 16'h0004, 1'b1, 1'b0);
        cycle("skid_release", 1'b1, 96'hC, 16'h0004, 1'b1, 1'b0);
        cycle("skid_release", 1'b0, '0, '0, 1'b1, 1'b0);
        cycle("skid_release", 1'b0, '0, '0, 1'b1, 1'b0);

        // Flush with two entries held and a competing input
        cycle("flush_fill", 1'b1, 96'h11, 16'h00FF, 1'b0, 1'b0);
        cycle("flush_fill", 1'b1, 96'h22, 16'h00FF, 1'b0, 1'b0);
        cycle("flush_fire", 1'b1, 96'h55, 16'h00FF, 1'b0, 1'b1);
        cycle("flush_after", 1'b0, '0, '0, 1'b1, 1'b0);
        cycle("flush_after", 1'b0, '0, '0, 1'b1, 1'b0);

        // Async reset between edges while one entry is held
        cycle("areset_fill", 1'b1, 96'h77, 16'h0010, 1'b0, 1'b0);
        in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("areset:out_valid", 128'(out_valid), 128'(0));
        check("areset:in_ready",  128'(in_ready),  128'(1));
        check("areset:occupancy", 128'(occupancy), 128'(0));
        check("areset:out_ctrl",  128'(out_ctrl),  128'(CTRL_RST));
        check("areset:out_data",  128'(out_data),  128'(0));
        #2 rst = 1'b1;
        q.delete();
`ifdef PIPE_STAGE_PERF_EN
        exp_stall = 0; exp_bubble = 0;
`endif
        @(negedge clk);

        // Backpressure toggle with continuous input
        for (int i = 0; i < 20; i++)
            cycle("toggle", 1'b1, rnd_data(), CTRL_W'($urandom()), (i % 2) == 0, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle("toggle_drain", 1'b0, '0, '0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
        // Hold TWO with input pending, then idle bubbles, then flush
        for (int i = 0; i < 7; i++)
            cycle("perf_stall", 1'b1, rnd_data(), 16'h0100, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle("perf_drain", 1'b0, '0, '0, 1'b1, 1'b0);
        cycle("perf_flush", 1'b0, '0, '0, 1'b1, 1'b1);
        cycle("perf_after", 1'b0, '0, '0, 1'b0, 1'b0);
`endif

        // Random traffic with occasional flushes
        for (int i = 0; i < 300; i++)
            cycle("random", $urandom_range(0, 3) != 0, rnd_data(), CTRL_W'($urandom()),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        compare("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register; generalised successor of the fixed ID/EX and EX/MEM registers.
- Carries a data bus plus a control-signal bus between two pipeline phases, e.g. ExecutePhase to MemoryPhase.
- Adds a valid/ready handshake with a 2-entry skid buffer, flush, and bubble insertion with zeroed control.
- Every inter-phase register in the core is instantiated from this one block.

Parameters:
- DATA_W, 96: width of the data payload (e.g. pc, alu_result, read_data2 concatenated).
- CTRL_W, 16: width of the control payload (regwrite, memwrite, memread, memtoreg, regdst, ...).
- CTRL_RST, 0: value driven on out_ctrl when the stage is empty, flushed, or in reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept; registered output.
- in_data  in  DATA_W  upstream data payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  downstream entry present.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  held data payload.
- out_ctrl  out  CTRL_W  held control; CTRL_RST when out_valid=0.
- occupancy  out  2  entry count, 0..2.

Behaviour:
- Reset (rst=0, async): state EMPTY; out_valid=0; in_ready=1; out_data=0; out_ctrl=CTRL_RST; occupancy=0; skid register=0.
- Storage: main register drives the outputs; a skid register holds one overflow entry.
- Transfer rules: upstream transfer when in_valid&in_ready at a clock edge; downstream transfer when out_valid&out_ready.
- Latency: accepted entry appears on out_* the next cycle. Throughput: 1 entry/cycle while out_ready=1.
- FSM EMPTY (occ 0):
  - in_valid: load main, go to ONE.
  - otherwise: stay.
- FSM ONE (occ 1):
  - in_valid & out_ready: main<=input, stay ONE.
  - in_valid & !out_ready: skid<=input, go to TWO.
  - !in_valid & out_ready: go to EMPTY; out_ctrl<=CTRL_RST.
  - neither: hold.
- FSM TWO (occ 2):
  - in_ready=0; no accept.
  - out_ready: main<=skid, go to ONE.
  - otherwise: hold.
- in_ready: registered, =1 in EMPTY/ONE, =0 in TWO. Updates the cycle after entering or leaving TWO. in_data/in_ctrl are ignored when in_ready=0.
- Ordering: strict FIFO; no entry is duplicated or reordered.
- flush=1 (highest priority):
  - Next state EMPTY; main and skid ctrl<=CTRL_RST; data may retain its value; in_ready<=1.
  - An in_valid accepted in the same cycle is discarded.
  - An outgoing transfer in the same cycle completes normally, since the output was already valid.
- Bubble: with out_valid=0, out_ctrl is always CTRL_RST, so no regwrite/memwrite leaks downstream.
- Reset mid-operation: all entries lost immediately; outputs return to reset values asynchronously.
- Data is not modified; widths pass through unchanged.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined: adds outputs stall_cnt[31:0] and bubble_cnt[31:0].
  - stall_cnt increments each cycle in_valid=1 & in_ready=0.
  - bubble_cnt increments each cycle out_valid=0 & out_ready=1.
  - Both saturate at 0xFFFFFFFF, clear on rst or flush, and are 0 after reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Streaming:
  - Stimulus: reset, then 8 consecutive in_valid beats, in_data=1..8, in_ctrl=0x0001, out_ready=1.
  - Required: out_data=1..8 on cycles 1..8 after the first accept; occupancy=1 throughout; in_ready=1 throughout.
- Skid fill:
  - Stimulus: out_ready=0, send 0xA then 0xB.
  - Required: occupancy=2; in_ready=0 the next cycle; 0xC held on in_data is not accepted.
  - Then: out_ready=1 yields 0xA, 0xB, 0xC in order.
- Flush with two held:
  - Stimulus: two entries held with ctrl=0x00FF, then flush=1 with in_valid=1 and data 0x55.
  - Required: next cycle out_valid=0, out_ctrl=CTRL_RST, occupancy=0; 0x55 is never output.
- Async reset mid-stream:
  - Stimulus: rst low for 3 ns between edges while occupancy=1.
  - Required: out_valid=0 and in_ready=1 immediately, before the next edge.
- Backpressure toggle:
  - Stimulus: out_ready alternating 1/0 for 20 cycles with continuous input.
  - Required: no loss, no duplication, strict order, occupancy never exceeds 2.
- PIPE_STAGE_PERF_EN build:
  - Stimulus: 5 cycles in TWO with in_valid=1.
  - Required: stall_cnt=5; 3 empty cycles with out_ready=1 give bubble_cnt=3; flush clears both to 0.
